// File: rtl/pipe_sched_if.sv
// pipe_sched_if: pipeline-scheduler bus bundling the psi_* controls and the pso_* step/stage/interrupt results
// Ports: psi_div, psi_pause_*, psi_flush, psi_soft_int*, psi_irq, psi_eret, psi_epc in; pso_tick, pso_stage_*, pso_set_pc, pso_epc, pso_int_id, pso_busy out
// PIPE_SCHED_PERF_EN adds psi_perf_clr in and pso_stall_ticks out
interface pipe_sched_if #(
  parameter int STAGES = 5,
  parameter int ADDR_W = 16,
  parameter int CNT_W = 4,
  parameter int NUM_IRQ = 4,
  parameter int DIV_W = 24
);
  logic [DIV_W-1:0] psi_div;
  logic psi_pause_request;
  logic [2:0] psi_pause_stage;
  logic [CNT_W-1:0] psi_pause_count;
  logic psi_flush;
  logic psi_soft_int;
  logic [3:0] psi_soft_int_id;
  logic [NUM_IRQ-1:0] psi_irq;
  logic psi_eret;
  logic [ADDR_W-1:0] psi_epc;
  logic pso_tick;
  logic [STAGES-1:0] pso_stage_en;
  logic [STAGES-1:0] pso_stage_bubble;
  logic pso_set_pc;
  logic [ADDR_W-1:0] pso_epc;
  logic [3:0] pso_int_id;
  logic pso_busy;
`ifdef PIPE_SCHED_PERF_EN
  logic psi_perf_clr;
  logic [15:0] pso_stall_ticks;
`endif
  modport master(
`ifdef PIPE_SCHED_PERF_EN
    output psi_perf_clr, input pso_stall_ticks,
`endif
    output psi_div, psi_pause_request, psi_pause_stage, psi_pause_count, psi_flush,
    output psi_soft_int, psi_soft_int_id, psi_irq, psi_eret, psi_epc,
    input pso_tick, pso_stage_en, pso_stage_bubble, pso_set_pc, pso_epc, pso_int_id, pso_busy
  );
  modport slave(
`ifdef PIPE_SCHED_PERF_EN
    input psi_perf_clr, output pso_stall_ticks,
`endif
    input psi_div, psi_pause_request, psi_pause_stage, psi_pause_count, psi_flush,
    input psi_soft_int, psi_soft_int_id, psi_irq, psi_eret, psi_epc,
    output pso_tick, pso_stage_en, pso_stage_bubble, pso_set_pc, pso_epc, pso_int_id, pso_busy
  );
endinterface

// File: rtl/pipe_sched.sv
// pipe_sched: step-tick divider, stage enable/bubble generation, hazard pause, flush and interrupt arbitration
// Ports: psi_clk system clock; psi_rst sync active-low reset; bus (pipe_sched_if.slave) carries all psi_*/pso_* signals
// PIPE_SCHED_PERF_EN adds a saturating stall-tick counter (pso_stall_ticks, cleared by psi_perf_clr)
module pipe_sched #(
  parameter int STAGES = 5,
  parameter int ADDR_W = 16,
  parameter int CNT_W = 4,
  parameter int NUM_IRQ = 4,
  parameter int DIV_W = 24
) (
  input logic psi_clk,
  input logic psi_rst,
  pipe_sched_if.slave bus
);
  typedef enum logic {RUN, STALL} state_t;
  state_t state, state_nx;
  logic [DIV_W-1:0] cnt;
  logic [CNT_W-1:0] rem, rem_nx;
  logic [2:0] stg_q, stg_nx, stg;
  logic [NUM_IRQ-1:0] irq_q, pend, win_mask;
  logic [STAGES-1:0] en, bub;
  logic [ADDR_W-1:0] epc_q;
  logic [3:0] id_q, hw_id;
  logic in_svc, tick, hold, accept;
  // reset gating keeps every tick-qualified output low while psi_rst is asserted
  assign tick = psi_rst && cnt >= bus.psi_div;
  assign hold = state == STALL || bus.psi_pause_request;
  assign stg = state == STALL ? stg_q : bus.psi_pause_stage;
  assign accept = tick && !hold && !in_svc && (bus.psi_soft_int || |pend);
  always_comb begin
    hw_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) if (pend[i]) hw_id = 4'(8 + i);
  end
  assign win_mask = bus.psi_soft_int ? '0 : NUM_IRQ'(1) << hw_id[2:0];
  always_ff @(posedge psi_clk)
    if (!psi_rst) begin
      state <= RUN;
      rem <= '0;
      stg_q <= '0;
    end else begin
      state <= state_nx;
      rem <= rem_nx;
      stg_q <= stg_nx;
    end
  always_comb begin
    state_nx = state;
    rem_nx = rem;
    stg_nx = stg_q;
    if (tick && state == STALL) begin
      rem_nx = rem - CNT_W'(1);
      state_nx = rem == CNT_W'(1) ? RUN : STALL;
    end else if (tick && bus.psi_pause_request) begin
      rem_nx = bus.psi_pause_count - CNT_W'(bus.psi_pause_count != '0);
      stg_nx = bus.psi_pause_stage;
      state_nx = rem_nx != '0 ? STALL : RUN;
    end
  end
  always_comb begin
    en = '0;
    bub = '0;
    for (int i = 0; i < STAGES; i++) begin
      en[i] = tick && (!hold || i > int'(stg));
      bub[i] = tick && (hold ? i == int'(stg) + 1 : (i == 1 && (accept || bus.psi_flush)) || (i == 2 && accept));
    end
  end
  always_ff @(posedge psi_clk)
    if (!psi_rst) begin
      cnt <= '0;
      irq_q <= '0;
      pend <= '0;
      in_svc <= 1'b0;
      epc_q <= '0;
      id_q <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + DIV_W'(1);
      irq_q <= bus.psi_irq;
      pend <= (pend & ~(accept ? win_mask : '0)) | (bus.psi_irq & ~irq_q);
      in_svc <= accept || (in_svc && !bus.psi_eret);
      if (accept) begin
        epc_q <= bus.psi_epc;
        id_q <= bus.psi_soft_int ? bus.psi_soft_int_id : hw_id;
      end
    end
  assign bus.pso_tick = tick;
  assign bus.pso_stage_en = en;
  assign bus.pso_stage_bubble = bub;
  assign bus.pso_set_pc = accept;
  assign bus.pso_epc = epc_q;
  assign bus.pso_int_id = id_q;
  assign bus.pso_busy = state == STALL || in_svc;
`ifdef PIPE_SCHED_PERF_EN
  logic [15:0] stall_ticks;
  always_ff @(posedge psi_clk)
    if (!psi_rst || bus.psi_perf_clr) stall_ticks <= '0;
    else if (tick && !(&en) && !(&stall_ticks)) stall_ticks <= stall_ticks + 16'd1;
  assign bus.pso_stall_ticks = stall_ticks;
`else
`endif
endmodule
